nios_system_keys_in: RTL and testbench
======================================

Name: nios_system_keys_in

Overview:
- Avalon-MM slave input PIO. It is the read-side counterpart of the LED output port.
- Samples WIDTH asynchronous push-button/switch lines, synchronises and debounces them, and latches qualifying edges into an edge-capture register.
- Raises a level interrupt to the Nios II CPU for unmasked captured edges.
- Sits on the system interconnect beside the LED port. Read latency is zero.

Parameters:
- WIDTH, 4, number of input lines (1..32).
- DEBOUNCE_CYCLES, 50000, cycles an input must hold a new value before it is accepted (>=1).
- EDGE_TYPE, 1, edge that sets capture bits: 0 = rising, 1 = falling, 2 = any.
- IDLE_LEVEL, all ones (WIDTH bits), reset value of the synchroniser and debounced-state registers.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  Avalon word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  raw asynchronous input lines.
- readdata  output  32  read data, combinational from address.
- irq  output  1  active-high level interrupt.

Behaviour:
- Reset (async, reset_n low):
  - sync1, sync2 and stable go to IDLE_LEVEL.
  - Per-bit debounce counters go to 0.
  - irq_mask goes to 0 and edge_capture goes to 0, so irq = 0.
- Synchroniser: two flops per bit, in_port -> sync1 -> sync2.
- Debounce, per bit i, each cycle:
  - If sync2[i] == stable[i], the counter clears to 0.
  - Otherwise, if the counter == DEBOUNCE_CYCLES-1, stable[i] <= sync2[i] and the counter clears.
  - Otherwise the counter increments.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1 and it never wraps.
- Latency: a clean step on in_port[i] reaches stable[i] exactly 2 + DEBOUNCE_CYCLES cycles later.
- A glitch shorter than DEBOUNCE_CYCLES cycles, after synchronisation, never changes stable.
- Edge detect uses stable vs. its previous-cycle copy stable_d (stable_d also resets to IDLE_LEVEL):
  - rise = stable & ~stable_d
  - fall = ~stable & stable_d
  - edge = rise, fall or (rise | fall) according to EDGE_TYPE.
- Register map (write = chipselect & ~write_n):
  - addr 0 DATA: read-only, readdata = zero-extended stable; writes ignored.
  - addr 1: reserved, reads 0, writes ignored.
  - addr 2 IRQ_MASK: RW, WIDTH bits, loaded from writedata[WIDTH-1:0]; reads zero-extended.
  - addr 3 EDGE_CAPTURE: read returns zero-extended edge_capture; write-1-to-clear per bit.
- edge_capture update: edge_capture <= (edge_capture & ~clr) | edge.
  - clr = writedata[WIDTH-1:0] when writing addr 3, else 0.
  - An edge in the same cycle as a clear of that bit wins: the bit stays 1.
- irq = |(edge_capture & irq_mask). It is combinational from registers, so no added cycle.
  - irq asserts the cycle after the capture bit sets.
  - irq deasserts the cycle after the clear or the mask write.
- Unused upper readdata bits are 0. Reads have no side effects.
- chipselect low: no register changes; readdata still reflects address.
- Reset mid-debounce: the counter is discarded. After release, inputs re-debounce from IDLE_LEVEL, and no spurious edge appears if the input equals IDLE_LEVEL.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4, EDGE_TYPE=1):
- Reset with in_port=4'hF, hold 20 cycles -> read addr 0 = 32'h0000000F, addr 3 = 0, irq = 0 throughout.
- Drive in_port[0]=0 cleanly -> addr 0 reads 32'h0000000E at cycle 6 after the change; edge_capture = 32'h1 one cycle later; irq stays 0 (mask 0).
- Write IRQ_MASK=4'h1 with edge_capture[0] set -> irq=1 next cycle. Write 32'h1 to addr 3 -> edge_capture=0 and irq=0 next cycle.
- Pulse in_port[1] low for 3 cycles, then high -> addr 0 stays 32'h0000000F and edge_capture[1] stays 0.
- Clear edge_capture[2] by writing 32'h4 to addr 3 in the same cycle stable[2] falls -> edge_capture[2] = 1 after the write.
- Assert reset_n low mid-debounce of in_port[3] (counter = 2), release with in_port=4'hF -> stable = 4'hF, no capture, irq = 0; writes to addr 0/1 leave all state unchanged.

Source files
------------

// File: rtl/nios_system_keys_in_if.sv
// Avalon-MM slave bus bundle for the key input PIO: address/strobe/data plus
// the combinational read data and the level interrupt back to the CPU.
interface nios_system_keys_in_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata,
      input  irq
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata,
      output irq
   );
endinterface

// File: rtl/nios_system_keys_in.sv
// Key/switch input PIO: two-flop synchroniser, per-bit debounce, edge capture
// with write-1-to-clear, maskable level interrupt and a zero-latency read port.
module nios_system_keys_in #(
   parameter int unsigned           WIDTH           = 4,
   parameter int unsigned           DEBOUNCE_CYCLES = 50000,
   parameter int unsigned           EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0]      IDLE_LEVEL      = {WIDTH{1'b1}}
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [WIDTH-1:0]         in_port_i,
   nios_system_keys_in_if.slave     bus
);

   localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] stable_prev_q;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
   logic [WIDTH-1:0] rise_s, fall_s, edge_s, clr_s;
   logic             wr_s;
   logic             unused_wdata_s;

   assign wr_s           = bus.chipselect & ~bus.write_n;
   assign unused_wdata_s = ^bus.writedata;

   // Synchroniser chain and previous-cycle copy of the debounced state
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync1_q       <= IDLE_LEVEL;
         sync2_q       <= IDLE_LEVEL;
         stable_prev_q <= IDLE_LEVEL;
      end else begin
         sync1_q       <= in_port_i;
         sync2_q       <= sync1_q;
         stable_prev_q <= stable_q;
      end
   end

   // Per-bit debounce: a new level must persist DEBOUNCE_CYCLES cycles to be accepted
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Debounced state and counters
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         stable_q <= IDLE_LEVEL;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         stable_q <= stable_d;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign rise_s = stable_q & ~stable_prev_q;
   assign fall_s = ~stable_q & stable_prev_q;

   // Select which debounced transitions count as capture events
   always_comb begin
      edge_s = '0;
      case (EDGE_TYPE)
         32'd0:   edge_s = rise_s;
         32'd1:   edge_s = fall_s;
         default: edge_s = rise_s | fall_s;
      endcase
   end

   // Register writes; a fresh edge beats a simultaneous clear of the same bit
   always_comb begin
      irq_mask_d = irq_mask_q;
      clr_s      = '0;
      if (wr_s && bus.address == 2'd2) begin
         irq_mask_d = bus.writedata[WIDTH-1:0];
      end else if (wr_s && bus.address == 2'd3) begin
         clr_s = bus.writedata[WIDTH-1:0];
      end else begin
         clr_s = '0;
      end
      edge_capture_d = (edge_capture_q & ~clr_s) | edge_s;
   end

   // Mask and capture registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         irq_mask_q     <= '0;
         edge_capture_q <= '0;
      end else begin
         irq_mask_q     <= irq_mask_d;
         edge_capture_q <= edge_capture_d;
      end
   end

   // Zero-latency read mux; reads never alter state
   always_comb begin
      bus.readdata = 32'h0000_0000;
      case (bus.address)
         2'd0:    bus.readdata = 32'(stable_q);
         2'd2:    bus.readdata = 32'(irq_mask_q);
         2'd3:    bus.readdata = 32'(edge_capture_q);
         default: bus.readdata = 32'h0000_0000;
      endcase
   end

   assign bus.irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_nios_system_keys_in.sv
// Directed bench for the key input PIO with a short debounce window (4 cycles).
module tb_nios_system_keys_in;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  in_port;
   logic [31:0] rd;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   nios_system_keys_in_if bus_if ();

   nios_system_keys_in #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .EDGE_TYPE       (1),
      .IDLE_LEVEL      (4'hF)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .in_port_i (in_port),
      .bus       (bus_if.slave)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus_if.address    = a;
      bus_if.writedata  = d;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      tick(1);
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'h0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus_if.address = a;
      #1;
      d = bus_if.readdata;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      in_port = 4'hF;
      tick(3);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         checks++;
         if (bus_if.irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq cycle %0d got %b exp 0", i, bus_if.irq);
         end
      end
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0000000F) begin
         errors++;
         $display("FAIL reset_data got %h exp 0000000f", rd);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL reset_capture got %h exp 00000000", rd);
      end
   endtask

   task automatic test_clean_step();
      in_port[0] = 1'b0;
      tick(5);
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0000000F) begin
         errors++;
         $display("FAIL step_early got %h exp 0000000f", rd);
      end
      tick(1);
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0000000E) begin
         errors++;
         $display("FAIL step_data got %h exp 0000000e", rd);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL step_capture_early got %h exp 00000000", rd);
      end
      tick(1);
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL step_capture got %h exp 00000001", rd);
      end
      checks++;
      if (bus_if.irq !== 1'b0) begin
         errors++;
         $display("FAIL step_irq_masked got %b exp 0", bus_if.irq);
      end
   endtask

   task automatic test_irq();
      bus_write(2'd2, 32'hFFFF_FFF1);
      checks++;
      if (bus_if.irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_on_mask got %b exp 1", bus_if.irq);
      end
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL mask_read got %h exp 00000001", rd);
      end
      bus_if.address    = 2'd2;
      bus_if.writedata  = 32'h0;
      bus_if.write_n    = 1'b0;
      bus_if.chipselect = 1'b0;
      tick(1);
      bus_if.write_n = 1'b1;
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL nocs_write got %h exp 00000001", rd);
      end
      bus_write(2'd3, 32'h1);
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL w1c_capture got %h exp 00000000", rd);
      end
      checks++;
      if (bus_if.irq !== 1'b0) begin
         errors++;
         $display("FAIL w1c_irq got %b exp 0", bus_if.irq);
      end
   endtask

   task automatic test_rising_ignored();
      in_port[0] = 1'b1;
      tick(10);
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0000000F) begin
         errors++;
         $display("FAIL rise_data got %h exp 0000000f", rd);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL rise_capture got %h exp 00000000", rd);
      end
   endtask

   task automatic test_glitch();
      in_port[1] = 1'b0;
      tick(3);
      in_port[1] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bus_read(2'd0, rd);
         checks++;
         if (rd !== 32'h0000000F) begin
            errors++;
            $display("FAIL glitch_data cycle %0d got %h exp 0000000f", i, rd);
         end
         tick(1);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL glitch_capture got %h exp 00000000", rd);
      end
   endtask

   task automatic test_clear_collision();
      in_port[2] = 1'b0;
      tick(6);
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0000000B) begin
         errors++;
         $display("FAIL coll_data got %h exp 0000000b", rd);
      end
      bus_write(2'd3, 32'h4);
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h4) begin
         errors++;
         $display("FAIL coll_edge_wins got %h exp 00000004", rd);
      end
      checks++;
      if (bus_if.irq !== 1'b0) begin
         errors++;
         $display("FAIL coll_irq got %b exp 0", bus_if.irq);
      end
      bus_write(2'd3, 32'h4);
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL coll_second_clear got %h exp 00000000", rd);
      end
      in_port[2] = 1'b1;
      tick(10);
   endtask

   task automatic test_reset_mid_debounce();
      bus_write(2'd2, 32'hF);
      in_port[3] = 1'b0;
      tick(4);
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0000000F) begin
         errors++;
         $display("FAIL mid_data got %h exp 0000000f", rd);
      end
      reset_n = 1'b0;
      in_port = 4'hF;
      tick(2);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         checks++;
         if (bus_if.irq !== 1'b0) begin
            errors++;
            $display("FAIL mid_irq cycle %0d got %b exp 0", i, bus_if.irq);
         end
      end
      bus_write(2'd0, 32'h0);
      bus_write(2'd1, 32'hFFFF_FFFF);
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0000000F) begin
         errors++;
         $display("FAIL post_data got %h exp 0000000f", rd);
      end
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL post_reserved got %h exp 00000000", rd);
      end
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL post_mask got %h exp 00000000", rd);
      end
      tick(1);
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL post_capture got %h exp 00000000", rd);
      end
      in_port[3] = 1'b0;
      tick(5);
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0000000F) begin
         errors++;
         $display("FAIL redebounce_early got %h exp 0000000f", rd);
      end
      tick(1);
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h00000007) begin
         errors++;
         $display("FAIL redebounce_data got %h exp 00000007", rd);
      end
      tick(1);
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h8) begin
         errors++;
         $display("FAIL redebounce_capture got %h exp 00000008", rd);
      end
      checks++;
      if (bus_if.irq !== 1'b0) begin
         errors++;
         $display("FAIL redebounce_irq got %b exp 0", bus_if.irq);
      end
   endtask

   initial begin
      reset_n           = 1'b0;
      in_port           = 4'hF;
      bus_if.address    = 2'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'h0;
      test_reset();
      test_clean_step();
      test_irq();
      test_rising_ignored();
      test_glitch();
      test_clear_collision();
      test_reset_mid_debounce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
